// File: rtl/wait_capture.sv
// wait_capture
// ------------
// Clocked two-stage delayed capture. When `enable` is sampled high in IDLE
// the block waits DLY_A cycles and then copies `b_in` into `a_out`. It waits
// a further DLY_C cycles, copies `d_in` into `c_out` and pulses `done`. It
// then holds in REARM until `enable` is seen low, so one enable window
// produces exactly one capture sequence.
//
// Parameters
//   WIDTH  data width of b_in/d_in/a_out/c_out
//   DLY_A  cycles from trigger edge to a_out load   (1 .. 2**CNT_W)
//   DLY_C  cycles from a_out load to c_out load     (1 .. 2**CNT_W)
//   CNT_W  delay counter width
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   enable   in   level trigger, sampled only in IDLE and REARM
//   b_in     in   data captured into a_out
//   d_in     in   data captured into c_out
//   a_out    out  registered copy of b_in
//   c_out    out  registered copy of d_in
//   a_valid  out  set on the a_out load, cleared on the next trigger
//   c_valid  out  set on the c_out load, cleared on the next trigger
//   busy     out  high while waiting (WAIT_A and WAIT_C)
//   done     out  one-cycle pulse coincident with the c_out load
module wait_capture #(
  parameter int WIDTH = 8,
  parameter int DLY_A = 10,
  parameter int DLY_C = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] c_out,
  output logic             a_valid,
  output logic             c_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_A = 2'd1,
    WAIT_C = 2'd2,
    REARM  = 2'd3
  } state_t;

  // The counter is loaded with DLY-1 so that a value of 0 on the trigger
  // edge still yields a full DLY cycles before the load edge.
  localparam logic [CNT_W-1:0] LOAD_A   = CNT_W'(DLY_A - 1);
  localparam logic [CNT_W-1:0] LOAD_C   = CNT_W'(DLY_C - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

  // Sequencer: state, delay counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      a_out   <= DATA_ZERO;
      c_out   <= DATA_ZERO;
      a_valid <= 1'b0;
      c_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // done is a single-cycle strobe; only the c_out load raises it.
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          // Level-sensitive: an enable already high on entry triggers here.
          if (enable) begin
            state_r <= WAIT_A;
            cnt_r   <= LOAD_A;
            a_valid <= 1'b0;
            c_valid <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_A: begin
          // enable is deliberately ignored while waiting; no abort path.
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            a_out   <= b_in;
            a_valid <= 1'b1;
            cnt_r   <= LOAD_C;
            state_r <= WAIT_C;
          end
        end
        WAIT_C: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            c_out   <= d_in;
            c_valid <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= REARM;
          end
        end
        REARM: begin
          // Re-arm only after the enable window has closed.
          if (!enable) begin
            state_r <= IDLE;
          end else begin
            state_r <= REARM;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wait_capture.sv
module tb_wait_capture;

  localparam int DLY = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] b_in, d_in, a_out, c_out;
  logic       a_valid, c_valid, busy, done;

  logic       en_m;
  logic [7:0] b_m, d_m, a_out_m, c_out_m;
  logic       a_valid_m, c_valid_m, busy_m, done_m;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit         is_c;
    int         at;
    logic [7:0] data;
  } ev_t;
  ev_t q[$];

  // Expected busy window of the current sequence on the main DUT.
  bit win_v = 1'b0;
  int win_k = 0;
  bit prev_av = 1'b0;

  wait_capture #(.WIDTH(8), .DLY_A(DLY), .DLY_C(DLY), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .b_in(b_in), .d_in(d_in),
    .a_out(a_out), .c_out(c_out), .a_valid(a_valid), .c_valid(c_valid),
    .busy(busy), .done(done)
  );

  wait_capture #(.WIDTH(8), .DLY_A(1), .DLY_C(1), .CNT_W(8)) dut_min (
    .clk(clk), .rst(rst), .enable(en_m), .b_in(b_m), .d_in(d_m),
    .a_out(a_out_m), .c_out(c_out_m), .a_valid(a_valid_m), .c_valid(c_valid_m),
    .busy(busy_m), .done(done_m)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Expect a sequence triggered at the next rising edge.
  task automatic expect_seq(input logic [7:0] a_exp, input logic [7:0] c_exp);
    int k;
    k = cyc + 1;
    q.push_back('{1'b0, k + DLY, a_exp});
    q.push_back('{1'b1, k + 2 * DLY, c_exp});
    win_k = k;
    win_v = 1'b1;
  endtask

  task automatic start(input logic [7:0] b, input logic [7:0] d,
                       input logic [7:0] a_exp, input logic [7:0] c_exp);
    b_in   = b;
    d_in   = d;
    enable = 1'b1;
    expect_seq(a_exp, c_exp);
  endtask

  // Scoreboard monitor for the main DUT, sampled on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      chk("busy_window", 32'(busy),
          32'(win_v && (cyc >= win_k) && (cyc < win_k + 2 * DLY)));
      if (a_valid && !prev_av) begin
        if (q.size() == 0) begin
          chk("unexpected_a_load", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          chk("a_kind", 32'(e.is_c), 32'(0));
          chk("a_cycle", 32'(cyc), 32'(e.at));
          chk("a_data", 32'(a_out), 32'(e.data));
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          chk("c_kind", 32'(e.is_c), 32'(1));
          chk("c_cycle", 32'(cyc), 32'(e.at));
          chk("c_data", 32'(c_out), 32'(e.data));
          chk("c_valid_with_done", 32'(c_valid), 32'(1));
        end
      end
    end
    prev_av <= a_valid;
  end

  initial begin
    rst = 1'b1; enable = 1'b0; b_in = 8'h00; d_in = 8'h00;
    en_m = 1'b0; b_m = 8'h00; d_m = 8'h00;
    tick(2);
    chk("rst_a_out", 32'(a_out), 32'(0));
    chk("rst_c_out", 32'(c_out), 32'(0));
    chk("rst_a_valid", 32'(a_valid), 32'(0));
    chk("rst_c_valid", 32'(c_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    tick(2);

    // Minimum delays on the DLY=1 instance.
    en_m = 1'b1; b_m = 8'h5A; d_m = 8'hA5;
    tick(1);
    chk("min_busy_k", 32'(busy_m), 32'(1));
    chk("min_avalid_k", 32'(a_valid_m), 32'(0));
    tick(1);
    chk("min_a_out_k1", 32'(a_out_m), 32'(8'h5A));
    chk("min_avalid_k1", 32'(a_valid_m), 32'(1));
    chk("min_busy_k1", 32'(busy_m), 32'(1));
    chk("min_done_k1", 32'(done_m), 32'(0));
    en_m = 1'b0;
    tick(1);
    chk("min_c_out_k2", 32'(c_out_m), 32'(8'hA5));
    chk("min_cvalid_k2", 32'(c_valid_m), 32'(1));
    chk("min_done_k2", 32'(done_m), 32'(1));
    chk("min_busy_k2", 32'(busy_m), 32'(0));
    tick(1);
    chk("min_done_k3", 32'(done_m), 32'(0));

    // Basic sequence.
    start(8'h07, 8'h55, 8'h07, 8'h55);
    tick(15);
    enable = 1'b0;
    tick(10);
    chk("basic_a_hold", 32'(a_out), 32'(8'h07));
    chk("basic_a_valid", 32'(a_valid), 32'(1));
    chk("basic_c_valid", 32'(c_valid), 32'(1));

    // Early drop of enable does not abort.
    start(8'h11, 8'h22, 8'h11, 8'h22);
    tick(3);
    enable = 1'b0;
    tick(25);
    chk("early_busy_idle", 32'(busy), 32'(0));
    chk("early_c_out", 32'(c_out), 32'(8'h22));

    // Data sampled exactly at the load edge.
    start(8'h07, 8'h55, 8'hAA, 8'h55);
    tick(10);
    b_in = 8'hAA;
    tick(1);
    chk("load_edge_a_out", 32'(a_out), 32'(8'hAA));
    b_in = 8'h11;
    enable = 1'b0;
    tick(15);
    chk("post_load_a_hold", 32'(a_out), 32'(8'hAA));

    // Sub-cycle enable pulse between edges: no trigger.
    enable = 1'b1;
    #2;
    enable = 1'b0;
    tick(5);
    chk("pulse_busy", 32'(busy), 32'(0));
    chk("pulse_a_valid_kept", 32'(a_valid), 32'(1));

    // Reset mid-sequence with enable held high.
    start(8'h01, 8'h02, 8'h01, 8'h02);
    tick(5);
    q.delete();
    win_v = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_a_out", 32'(a_out), 32'(0));
    chk("midrst_c_out", 32'(c_out), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_a_valid", 32'(a_valid), 32'(0));
    tick(2);
    chk("midrst_done", 32'(done), 32'(0));
    b_in = 8'h3C; d_in = 8'hC3;
    rst = 1'b0;
    expect_seq(8'h3C, 8'hC3);
    tick(24);
    chk("rearm_busy", 32'(busy), 32'(0));
    chk("rearm_c_out", 32'(c_out), 32'(8'hC3));
    tick(5);
    enable = 1'b0;
    tick(3);

    // Enable high across reset release, then low, then a second trigger.
    rst = 1'b1;
    enable = 1'b1;
    tick(2);
    b_in = 8'h66; d_in = 8'h99;
    rst = 1'b0;
    expect_seq(8'h66, 8'h99);
    tick(3);
    enable = 1'b0;
    tick(25);
    chk("init_a_valid", 32'(a_valid), 32'(1));
    chk("init_c_valid", 32'(c_valid), 32'(1));
    start(8'h77, 8'h88, 8'h77, 8'h88);
    tick(1);
    chk("retrig_a_valid_clr", 32'(a_valid), 32'(0));
    chk("retrig_c_valid_clr", 32'(c_valid), 32'(0));
    chk("retrig_a_hold", 32'(a_out), 32'(8'h66));
    tick(3);
    enable = 1'b0;
    tick(22);

    chk("scoreboard_empty", 32'(q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
